// File: rtl/prod_bcd_pkg.sv
// Shared constants and state encoding for the product-to-BCD converter.
// Default geometry matches the 4-bit array multiplier feeding this block.
package prod_bcd_pkg;

  localparam int DEF_BITS   = 4;
  localparam int DEF_PROD_W = 2 * DEF_BITS;
  localparam int DEF_DIGITS = 3;

  localparam int DIGIT_W = 4;

  // Double-dabble correction: a digit of 5 or more gets 3 added before the
  // shift, so that the doubled value carries correctly into the next digit.
  localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [DIGIT_W-1:0] ADJ_ADD    = 4'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/dd_adjust_digit.sv
// One BCD digit's double-dabble pre-shift correction: +3 when the digit is
// 5 or more. Purely combinational; no carry leaves the digit.
module dd_adjust_digit
  import prod_bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  // Add-3 correction when the digit would overflow 9 after doubling.
  always_comb begin
    dout = (din >= ADJ_THRESH) ? din + ADJ_ADD : din;
  end

endmodule

// File: rtl/prod_bcd_conv.sv
// Sequential binary-to-BCD converter behind the 4-bit array multiplier.
// Captures a product on a valid/ready handshake, runs one double-dabble
// shift per clock, then holds the packed BCD result until it is taken.
// Optional build macro: LEADING_ZERO_BLANK_EN adds the registered 'blank'
// output marking leading-zero digits (digit 0 is never blanked).
module prod_bcd_conv
  import prod_bcd_pkg::*;
#(
  parameter int BITS   = DEF_BITS,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*BITS-1:0]       product,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic                    busy
`ifdef LEADING_ZERO_BLANK_EN
  ,
  output logic [DIGITS-1:0]       blank
`endif
);

  localparam int PROD_W = 2 * BITS;
  localparam int ACC_W  = DIGIT_W * DIGITS;
  localparam int CNT_W  = (PROD_W > 1) ? $clog2(PROD_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PROD_W - 1);

  state_t            state_q, state_d;
  logic [PROD_W-1:0] bin_q;
  logic [ACC_W-1:0]  acc_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [ACC_W-1:0]  acc_adj;
  logic [ACC_W-1:0]  acc_shift;
  logic [PROD_W-1:0] bin_shift;
  logic              accept;
  logic              last_shift;

  // Per-digit add-3 correction ahead of each shift.
  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    dd_adjust_digit u_adj (
      .din  (acc_q[k*DIGIT_W +: DIGIT_W]),
      .dout (acc_adj[k*DIGIT_W +: DIGIT_W])
    );
  end

  assign {acc_shift, bin_shift} = {acc_adj, bin_q} << 1;

  assign accept     = in_valid && (state_q == IDLE);
  assign last_shift = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  assign bcd        = acc_q;

  // State register; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, regardless of block order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake/status outputs.
  always_comb begin
    // NOTE: every output gets a default before the case; a path that left
    // one unassigned would infer a latch.
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_shift) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load on accept, one double-dabble step per SHIFT cycle.
  // The accumulator doubles as the bcd output and holds through DONE/IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      bin_q <= product;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (state_q == SHIFT) begin
      bin_q <= bin_shift;
      acc_q <= acc_shift;
      cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_d;

  // Leading-zero mask of the final accumulator value; digit 0 always shown.
  always_comb begin
    logic upper_zero;
    blank_d    = '0;
    upper_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero && (acc_shift[k*DIGIT_W +: DIGIT_W] == '0);
      blank_d[k] = upper_zero;
    end
  end

  // Mask is registered alongside the result on the final shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             blank <= '0;
    else if (accept)     blank <= '0;
    else if (last_shift) blank <= blank_d;
  end
`endif

endmodule
